// File: rtl/stall_ctrl.sv
// Hazard/stall controller: compares D-stage operand Tuse against E/M producer
// Tnew, sequences the shared MDU busy window and counts stalled cycles.
module stall_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_A1,
  input  logic [4:0]  D_A2,
  input  logic [1:0]  D_Tuse_1,
  input  logic [1:0]  D_Tuse_2,
  input  logic        D_is_md,
  input  logic [4:0]  E_A3,
  input  logic [1:0]  E_Tnew,
  input  logic [4:0]  M_A3,
  input  logic [1:0]  M_Tnew,
  input  logic        E_start_mult,
  input  logic        E_start_div,
  output logic        stall,
  output logic        F_en,
  output logic        D_en,
  output logic        E_clr,
  output logic        md_busy,
  output logic [3:0]  md_cnt,
  output logic [31:0] stall_cycles
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  logic        stall_rs;
  logic        stall_rt;
  logic        stall_md;

  logic [3:0]  md_cnt_d,       md_cnt_q;
  logic        md_busy_d,      md_busy_q;
  logic [31:0] stall_cycles_d, stall_cycles_q;

  // A Tuse of 3 can never be below a 2-bit Tnew of at most 2, so unused
  // operands drop out of the comparison without a separate qualifier.
  always_comb begin
    stall_rs = ((D_A1 == E_A3) && (E_A3 != '0) && (D_Tuse_1 < E_Tnew)) ||
               ((D_A1 == M_A3) && (M_A3 != '0) && (D_Tuse_1 < M_Tnew));
    stall_rt = ((D_A2 == E_A3) && (E_A3 != '0) && (D_Tuse_2 < E_Tnew)) ||
               ((D_A2 == M_A3) && (M_A3 != '0) && (D_Tuse_2 < M_Tnew));
    stall_md = D_is_md && (md_busy_q || E_start_mult || E_start_div);
  end

  always_comb begin
    stall = stall_rs || stall_rt || stall_md;
    F_en  = ~stall;
    D_en  = ~stall;
    E_clr = stall;
  end

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (E_start_div) begin
      md_cnt_d = DIV_LOAD;
    end else if (E_start_mult) begin
      md_cnt_d = MULT_LOAD;
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - 4'd1;
    end
    md_busy_d = (md_cnt_d != '0);
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt_q       <= '0;
      md_busy_q      <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      md_cnt_q       <= md_cnt_d;
      md_busy_q      <= md_busy_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign md_cnt       = md_cnt_q;
  assign md_busy      = md_busy_q;
  assign stall_cycles = stall_cycles_q;

endmodule
